snake_matrix_scan: RTL and testbench
====================================

# snake_matrix_scan

Downstream display stage of the snake game core: consumes the packed snake body vector, apple, barrier, dead and win flags, and drives a time-multiplexed 8x8 bicolour (red/green) LED dot matrix. It decodes cell positions into row/column pixels, scans one row at a time and blinks game-over feedback. Each frame uses a coherent snapshot of the game inputs, so a mid-frame game update never tears the image.

## Interface
- SCAN_DIV, 1000: clk cycles per row slot; legal range 2..65535.
- BLINK_FRAMES, 32: frames per blink phase toggle; legal range 1..255.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- snake  in  72  nine 8-bit positions; [71:64] is the head, [63:56]..[7:0] are body segments; 0 means an unused segment.
- apple  in  8  apple position.
- barrier  in  8  barrier position.
- dead_flag  in  1  game-over indication.
- win_flag  in  1  win indication.
- row_sel  out  8  active-low one-hot row enable; bit k drives matrix row k.
- col_red  out  8  active-high red column drive; bit c drives column c.
- col_green  out  8  active-high green column drive.
- frame_start  out  1  one-cycle pulse on the first cycle that row 0 is driven.

## Operation
- Position decode: p is valid iff 12 <= p <= 89 and (p mod 10) is in 2..9. For a valid p, row = p/10 - 1 and col = (p mod 10) - 2, each 0..7. An invalid p, including 0, lights no pixel.
- Snapshot: the block registers snake, apple, barrier, dead_flag and win_flag together.
  - A load occurs on the edge where row_idx wraps 7->0.
  - A load also occurs on the first clk edge after rst deasserts (load_pending flag, set by reset).
  - All pixel logic uses only the snapshot.
- Pixel colours in normal mode, OR-combined per pixel:
  - Body segments [63:0]: green.
  - Head: red and green.
  - Apple: red.
  - Barrier: red while blink_phase = 1, otherwise off.
- Override priority (dead > win > normal):
  - Snapshot dead_flag = 1: all 64 pixels red while blink_phase = 1, all off while blink_phase = 0.
  - Else snapshot win_flag = 1: all 64 pixels green, steady.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1.
  - At terminal count, row_idx increments 0..7 and wraps to 0.
- Blink:
  - frame_cnt increments at each 7->0 wrap.
  - When frame_cnt reaches BLINK_FRAMES-1, frame_cnt clears to 0 and blink_phase toggles.
- Simultaneous events: a wrap and a blink toggle on the same edge both take effect. The new snapshot and the new blink_phase apply together to the next frame.
- Reset mid-frame: all outputs blank immediately (asynchronous); the scan restarts at row 0 after release.

## Timing
- Reset values:
  - Outputs: row_sel = 8'hFF, col_red = 0, col_green = 0, frame_start = 0.
  - Internal: row_idx = 0, prescaler = 0, frame_cnt = 0, blink_phase = 0, snapshot = 0, load_pending = 1.
- All outputs are registered, with 1-cycle latency from the row_idx/snapshot state.
- Row k is driven for exactly SCAN_DIV consecutive cycles. Frame period = 8*SCAN_DIV cycles.
- frame_start is high for 1 cycle, aligned with the first driven cycle of row 0.
- Input changes affect the display at the earliest one frame later; inputs between snapshots are ignored.

## Configuration
- SNAKE_SCAN_GHOST_BLANK_EN defined: the first cycle of every row slot (prescaler = 0, seen at the outputs 1 cycle later) drives row_sel = 8'hFF and all column bits 0, to suppress ghosting. Row lit time is SCAN_DIV-1 cycles; the frame period is unchanged. frame_start stays aligned with the first cycle of row 0's slot, which is the blank cycle.
- Not defined: no blank cycle; every row is lit for all SCAN_DIV cycles.

## Structure
- Shared package snake_pkg holds:
  - GRID_N = 8, POS_MIN = 12, POS_MAX = 89, ROW_STRIDE = 10, COL_OFFSET = 2.
  - SEG_COUNT = 9, SEG_W = 8, HEAD_LSB = 64.
  - A typedef for an 8-bit cell position.
- Sub-module snake_cell_decode: a combinational 8-bit position -> {valid, row[2:0], col[2:0]} decoder, using compares, no divider. Instantiated 11 times (9 segments, apple, barrier).

## Test plan
- Reset, then hold rst low mid-frame -> row_sel = 8'hFF and columns 0 immediately; after release, frame_start fires within 8*SCAN_DIV+2 cycles.
- Snake head 12, other segments 0, apple 45, barrier 0 -> row 0 shows col_red = col_green = 8'h01; row 3 shows col_red = 8'h08, col_green = 0; all other rows blank.
- Body segment 51 and apple 90 -> no pixel lit for either, since both positions are invalid.
- Change apple from 45 to 23 in the middle of row 2 -> the current frame still shows 45; the next frame shows row 1 col_red = 8'h02.
- Set dead_flag with win_flag also set, BLINK_FRAMES = 2 -> all rows col_red = 8'hFF and col_green = 0 on alternating 2-frame phases, off otherwise.
- With SNAKE_SCAN_GHOST_BLANK_EN defined and SCAN_DIV = 4 -> each row slot shows 1 blank cycle followed by 3 lit cycles; frame period is 32 cycles.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants and types for the snake game display path.
package snake_pkg;

    localparam int GRID_N    = 8;
    localparam int SEG_COUNT = 9;
    localparam int SEG_W     = 8;
    localparam int HEAD_LSB  = 64;

    typedef logic [SEG_W-1:0] cell_pos_t;

    localparam cell_pos_t POS_MIN    = 8'd12;
    localparam cell_pos_t POS_MAX    = 8'd89;
    localparam cell_pos_t ROW_STRIDE = 8'd10;
    localparam cell_pos_t COL_OFFSET = 8'd2;

endpackage

// File: rtl/snake_matrix_scan_if.sv
// Game-state inputs and LED matrix drive outputs of the display scanner.
interface snake_matrix_scan_if;
    import snake_pkg::*;

    logic [SEG_COUNT*SEG_W-1:0] snake;
    cell_pos_t                  apple;
    cell_pos_t                  barrier;
    logic                       dead_flag;
    logic                       win_flag;
    logic [GRID_N-1:0]          row_sel;
    logic [GRID_N-1:0]          col_red;
    logic [GRID_N-1:0]          col_green;
    logic                       frame_start;

    modport master (
        output snake, apple, barrier, dead_flag, win_flag,
        input  row_sel, col_red, col_green, frame_start
    );

    modport slave (
        input  snake, apple, barrier, dead_flag, win_flag,
        output row_sel, col_red, col_green, frame_start
    );

endinterface

// File: rtl/snake_cell_decode.sv
// Position code -> grid cell. Tens digit is found by a ladder of compares
// instead of a divider; the ones digit is the remainder after that subtraction.
module snake_cell_decode
    import snake_pkg::*;
(
    input  cell_pos_t  pos,
    output logic       valid,
    output logic [2:0] row,
    output logic [2:0] col
);

    logic [3:0] tens;
    cell_pos_t  ones;

    always_comb begin
        tens = 4'd0;
        ones = pos;
        for (int t = 1; t <= GRID_N; t++) begin
            if (pos >= 8'(t * ROW_STRIDE)) begin
                tens = 4'(t);
                ones = pos - 8'(t * ROW_STRIDE);
            end
        end
        valid = (pos >= POS_MIN) && (pos <= POS_MAX) && (ones >= COL_OFFSET);
        row   = 3'(tens - 4'd1);
        col   = 3'(ones - COL_OFFSET);
    end

endmodule

// File: rtl/snake_matrix_scan.sv
// Row-multiplexed 8x8 red/green matrix driver with per-frame input snapshot.
// Optional SNAKE_SCAN_GHOST_BLANK_EN blanks the first cycle of every row slot.
module snake_matrix_scan
    import snake_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    snake_matrix_scan_if.slave   bus
);

    logic [15:0]                presc_q, presc_d;
    logic [2:0]                 row_idx_q, row_idx_d;
    logic [7:0]                 frame_cnt_q, frame_cnt_d;
    logic                       blink_phase_q, blink_phase_d;
    logic                       load_pending_q, load_pending_d;
    logic [SEG_COUNT*SEG_W-1:0] snake_q, snake_d;
    cell_pos_t                  apple_q, apple_d, barrier_q, barrier_d;
    logic                       dead_q, dead_d, win_q, win_d;
    logic [GRID_N-1:0]          row_sel_q, row_sel_d;
    logic [GRID_N-1:0]          col_red_q, col_red_d, col_green_q, col_green_d;
    logic                       frame_start_q, frame_start_d;

    logic                       seg_valid [SEG_COUNT];
    logic [2:0]                 seg_row   [SEG_COUNT];
    logic [2:0]                 seg_col   [SEG_COUNT];
    logic                       apple_valid, barrier_valid;
    logic [2:0]                 apple_row, apple_col, barrier_row, barrier_col;
    logic [GRID_N-1:0]          red_row, green_row;
    logic                       load;

    genvar gi;
    generate
        for (gi = 0; gi < SEG_COUNT; gi++) begin : g_seg
            snake_cell_decode u_dec (
                .pos   (snake_q[gi*SEG_W +: SEG_W]),
                .valid (seg_valid[gi]),
                .row   (seg_row[gi]),
                .col   (seg_col[gi])
            );
        end
    endgenerate

    snake_cell_decode u_apple_dec (
        .pos(apple_q), .valid(apple_valid), .row(apple_row), .col(apple_col)
    );

    snake_cell_decode u_barrier_dec (
        .pos(barrier_q), .valid(barrier_valid), .row(barrier_row), .col(barrier_col)
    );

    // Column pattern of the row currently addressed, from the snapshot only.
    always_comb begin
        red_row   = '0;
        green_row = '0;
        for (int i = 0; i < SEG_COUNT; i++) begin
            if (seg_valid[i] && (seg_row[i] == row_idx_q)) begin
                green_row[seg_col[i]] = 1'b1;
                if (i * SEG_W == HEAD_LSB)
                    red_row[seg_col[i]] = 1'b1;
            end
        end
        if (apple_valid && (apple_row == row_idx_q))
            red_row[apple_col] = 1'b1;
        if (blink_phase_q && barrier_valid && (barrier_row == row_idx_q))
            red_row[barrier_col] = 1'b1;
        if (dead_q) begin
            red_row   = blink_phase_q ? '1 : '0;
            green_row = '0;
        end else if (win_q) begin
            red_row   = '0;
            green_row = '1;
        end
    end

    always_comb begin
        presc_d        = presc_q;
        row_idx_d      = row_idx_q;
        frame_cnt_d    = frame_cnt_q;
        blink_phase_d  = blink_phase_q;
        load_pending_d = load_pending_q;
        load           = 1'b0;

        // The post-reset load cycle holds the scan so row 0 starts on a real snapshot.
        if (load_pending_q) begin
            load           = 1'b1;
            load_pending_d = 1'b0;
        end else if (presc_q == 16'(SCAN_DIV - 1)) begin
            presc_d   = '0;
            row_idx_d = row_idx_q + 3'd1;
            if (row_idx_q == 3'd7) begin
                load = 1'b1;
                if (frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
                    frame_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
        end else begin
            presc_d = presc_q + 16'd1;
        end

        snake_d   = load ? bus.snake     : snake_q;
        apple_d   = load ? bus.apple     : apple_q;
        barrier_d = load ? bus.barrier   : barrier_q;
        dead_d    = load ? bus.dead_flag : dead_q;
        win_d     = load ? bus.win_flag  : win_q;

        row_sel_d     = '1;
        col_red_d     = '0;
        col_green_d   = '0;
        frame_start_d = 1'b0;
        if (!load_pending_q) begin
            row_sel_d     = ~(8'h01 << row_idx_q);
            col_red_d     = red_row;
            col_green_d   = green_row;
            frame_start_d = (row_idx_q == 3'd0) && (presc_q == 16'd0);
`ifdef SNAKE_SCAN_GHOST_BLANK_EN
            if (presc_q == 16'd0) begin
                row_sel_d   = '1;
                col_red_d   = '0;
                col_green_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q        <= '0;
            row_idx_q      <= '0;
            frame_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            load_pending_q <= 1'b1;
            snake_q        <= '0;
            apple_q        <= '0;
            barrier_q      <= '0;
            dead_q         <= 1'b0;
            win_q          <= 1'b0;
            row_sel_q      <= '1;
            col_red_q      <= '0;
            col_green_q    <= '0;
            frame_start_q  <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            row_idx_q      <= row_idx_d;
            frame_cnt_q    <= frame_cnt_d;
            blink_phase_q  <= blink_phase_d;
            load_pending_q <= load_pending_d;
            snake_q        <= snake_d;
            apple_q        <= apple_d;
            barrier_q      <= barrier_d;
            dead_q         <= dead_d;
            win_q          <= win_d;
            row_sel_q      <= row_sel_d;
            col_red_q      <= col_red_d;
            col_green_q    <= col_green_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign bus.row_sel     = row_sel_q;
    assign bus.col_red     = col_red_q;
    assign bus.col_green   = col_green_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_snake_matrix_scan.sv
// Directed bench for snake_matrix_scan: frame-level reference model plus literal spot checks.
module tb_snake_matrix_scan;

    localparam int SD = 4;
    localparam int BF = 2;
    localparam int P  = 8 * SD;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic chk_en = 1'b0;
    logic found;

    snake_matrix_scan_if bus ();

    snake_matrix_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Column of position p if it lies on row r, else -1.
    function automatic int pix_col(input int p, input int r);
        if (p < 12 || p > 89 || (p % 10) < 2) return -1;
        if (p / 10 - 1 != r) return -1;
        return p % 10 - 2;
    endfunction

    function automatic void model_row(input logic [89:0] s, input logic ph, input int r,
                                      output logic [7:0] red, output logic [7:0] grn);
        int c;
        red = 8'h00;
        grn = 8'h00;
        if (s[1]) begin
            red = ph ? 8'hFF : 8'h00;
            return;
        end
        if (s[0]) begin
            grn = 8'hFF;
            return;
        end
        for (int i = 0; i < 9; i++) begin
            c = pix_col(int'(s[18 + i*8 +: 8]), r);
            if (c >= 0) begin
                grn[c] = 1'b1;
                if (i == 8) red[c] = 1'b1;
            end
        end
        c = pix_col(int'(s[10 +: 8]), r);
        if (c >= 0) red[c] = 1'b1;
        c = pix_col(int'(s[2 +: 8]), r);
        if (c >= 0 && ph) red[c] = 1'b1;
    endfunction

    // Edges since reset release; snapshot taken at edge 1 and every P edges after.
    int          n_q;
    logic [89:0] nxt_q, cur_q;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q <= 0;
        end else begin
            n_q <= n_q + 1;
            if (n_q >= 1 && ((n_q - 1) % P) == 0)
                cur_q <= nxt_q;
            if ((n_q % P) == 0)
                nxt_q <= {bus.snake, bus.apple, bus.barrier, bus.dead_flag, bus.win_flag};
        end
    end

    always @(negedge clk) begin
        logic [7:0] er, eg, ers, efs;
        int k, r, f;
        if (chk_en) begin
            er = 8'h00; eg = 8'h00; ers = 8'hFF; efs = 8'h00;
            if (rst && n_q >= 2) begin
                k = n_q - 2;
                r = (k / SD) % 8;
                f = k / P;
                model_row(cur_q, ((f / BF) % 2) == 1, r, er, eg);
                ers = ~(8'h01 << r);
                efs = ((k % P) == 0) ? 8'h01 : 8'h00;
`ifdef SNAKE_SCAN_GHOST_BLANK_EN
                if ((k % SD) == 0) begin
                    er = 8'h00; eg = 8'h00; ers = 8'hFF;
                end
`endif
            end
            check8("cyc_row_sel", bus.row_sel, ers);
            check8("cyc_col_red", bus.col_red, er);
            check8("cyc_col_green", bus.col_green, eg);
            check8("cyc_frame_start", {7'b0, bus.frame_start}, efs);
        end
    end

    task automatic wait_fs(input string name);
        found = 1'b0;
        for (int i = 0; i < 3 * P && !found; i++) begin
            @(negedge clk);
            if (bus.frame_start) found = 1'b1;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL %s: frame_start timeout", name);
        end
    endtask

    task automatic wait_row(input string name, input int r);
        logic [7:0] want;
        want = ~(8'h01 << r);
        found = 1'b0;
        for (int i = 0; i < 2 * P && !found; i++) begin
            @(negedge clk);
            if (bus.row_sel == want) found = 1'b1;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL %s: row %0d timeout", name, r);
        end
    endtask

    task automatic check_row(input string name, input int r, input logic [7:0] red, input logic [7:0] grn);
        wait_row(name, r);
        check8({name, "_red"}, bus.col_red, red);
        check8({name, "_green"}, bus.col_green, grn);
    endtask

    logic [7:0] dv [4];
    logic [7:0] dg [4];
    int         cnt;

    initial begin
        bus.snake = '0; bus.apple = '0; bus.barrier = '0;
        bus.dead_flag = 1'b0; bus.win_flag = 1'b0;
        repeat (3) @(negedge clk);
        check8("reset_row_sel", bus.row_sel, 8'hFF);
        check8("reset_col_red", bus.col_red, 8'h00);
        check8("reset_col_green", bus.col_green, 8'h00);
        check8("reset_frame_start", {7'b0, bus.frame_start}, 8'h00);
        chk_en = 1'b1;

        bus.snake = {8'd12, 64'd0};
        bus.apple = 8'd45;
        rst = 1'b1;
        wait_fs("head_fs0"); wait_fs("head_fs1");
        check_row("head_row0", 0, 8'h01, 8'h01);
        check_row("apple_row3", 3, 8'h08, 8'h00);
        check_row("blank_row5", 5, 8'h00, 8'h00);

        wait_fs("tear_fs");
        wait_row("tear_row2", 2);
        bus.apple = 8'd23;
        check_row("tear_row3", 3, 8'h08, 8'h00);
        wait_fs("tear_next");
        check_row("new_apple_row1", 1, 8'h02, 8'h00);
        check_row("old_apple_gone", 3, 8'h00, 8'h00);

        bus.snake = {8'd12, 48'd0, 8'd34, 8'd51};
        bus.apple = 8'd90;
        bus.barrier = 8'd77;
        wait_fs("inv_fs0"); wait_fs("inv_fs1");
        check_row("inv_row0", 0, 8'h01, 8'h01);
        check_row("body34_row2", 2, 8'h00, 8'h04);
        check_row("inv51_row4", 4, 8'h00, 8'h00);
        repeat (2 * BF) wait_fs("barrier_frames");

        bus.win_flag = 1'b1;
        wait_fs("win_fs0"); wait_fs("win_fs1");
        check_row("win_row5", 5, 8'h00, 8'hFF);

        bus.dead_flag = 1'b1;
        wait_fs("dead_fs0"); wait_fs("dead_fs1");
        for (int i = 0; i < 4; i++) begin
            wait_fs("dead_fsn");
            wait_row("dead_row0", 0);
            dv[i] = bus.col_red;
            dg[i] = bus.col_green;
        end
        check8("dead_pair0", dv[1], dv[0]);
        check8("dead_pair1", dv[3], dv[2]);
        check8("dead_alt", dv[2], ~dv[0]);
        check8("dead_full", dv[0] | dv[2], 8'hFF);
        check8("dead_green", dg[0] | dg[1] | dg[2] | dg[3], 8'h00);

        bus.dead_flag = 1'b0;
        bus.win_flag = 1'b0;
        wait_fs("period_fs0");
`ifdef SNAKE_SCAN_GHOST_BLANK_EN
        check8("ghost_fs_blank", bus.row_sel, 8'hFF);
        @(negedge clk);
        check8("ghost_row0_lit", bus.row_sel, 8'hFE);
        cnt = 1;
`else
        check8("fs_row0", bus.row_sel, 8'hFE);
        cnt = 0;
`endif
        found = 1'b0;
        while (!found && cnt < 3 * P) begin
            @(negedge clk);
            cnt++;
            if (bus.frame_start) found = 1'b1;
        end
        check8("frame_period", 8'(cnt), 8'(P));

        wait_row("rst_row4", 4);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check8("rst_async_row_sel", bus.row_sel, 8'hFF);
        check8("rst_async_red", bus.col_red, 8'h00);
        check8("rst_async_green", bus.col_green, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        found = 1'b0;
        for (int i = 0; i < P + 2 && !found; i++) begin
            @(negedge clk);
            if (bus.frame_start) found = 1'b1;
        end
        check8("rst_restart_fs", {7'b0, found}, 8'h01);
        check_row("rst_row0", 0, 8'h01, 8'h01);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
